// File: rtl/mem_bus_pkg.sv
// Shared constants for the memory bus arbiter: FSM state encoding, default
// address map and the UART status word layout.
package mem_bus_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SRAM_ACC  = 3'd1;
    localparam logic [2:0] ST_UART_RD   = 3'd2;
    localparam logic [2:0] ST_UART_WR   = 3'd3;
    localparam logic [2:0] ST_UART_WAIT = 3'd4;
    localparam logic [2:0] ST_DONE      = 3'd5;

    localparam logic [15:0] DEF_RAM1_BASE = 16'h8000;
    localparam logic [15:0] DEF_UART_DATA = 16'hBF00;
    localparam logic [15:0] DEF_UART_STAT = 16'hBF01;

    function automatic logic [15:0] uart_status(input logic data_ready,
                                                input logic tbre,
                                                input logic tsre);
        return {14'b0, data_ready, tbre & tsre};
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_uart_port.sv
// UART strobe sequencing for the bus arbiter: rdn/wrn pulse timing, the
// tbre/tsre completion wait and, with BUS_TIMEOUT_EN, the wait watchdog.
module uart_port
    import mem_bus_pkg::*;
#(
    parameter int UART_PULSE  = 2,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] state,
    input  logic       launch_rd,
    input  logic       launch_wr,
    input  logic       tbre,
    input  logic       tsre,
    output logic       rdn,
    output logic       wrn,
    output logic       pulse_done,
`ifdef BUS_TIMEOUT_EN
    output logic       timeout,
`endif
    output logic       wait_ok
);

    localparam int PW = (UART_PULSE > 1) ? $clog2(UART_PULSE) : 1;

    logic [PW-1:0] pcnt;
    logic          tbre_seen;
    logic          tsre_seen;
    logic          in_pulse;

    assign in_pulse   = (state == ST_UART_RD) || (state == ST_UART_WR);
    assign pulse_done = in_pulse && (pcnt == '0);
    // Either flag may arrive first; each is remembered once seen.
    assign wait_ok    = (state == ST_UART_WAIT) && (tbre_seen || tbre) && (tsre_seen || tsre);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt      <= '0;
            rdn       <= 1'b1;
            wrn       <= 1'b1;
            tbre_seen <= 1'b0;
            tsre_seen <= 1'b0;
        end else if (launch_rd || launch_wr) begin
            pcnt      <= PW'(UART_PULSE - 1);
            rdn       <= ~launch_rd;
            wrn       <= ~launch_wr;
            tbre_seen <= 1'b0;
            tsre_seen <= 1'b0;
        end else if (in_pulse) begin
            if (pulse_done) begin
                rdn <= 1'b1;
                wrn <= 1'b1;
            end else begin
                pcnt <= pcnt - PW'(1);
            end
        end else if (state == ST_UART_WAIT) begin
            tbre_seen <= tbre_seen | tbre;
            tsre_seen <= tsre_seen | tsre;
        end
    end

`ifdef BUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] tcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt <= '0;
        end else if (state == ST_UART_WR) begin
            tcnt <= TW'(TIMEOUT_CYC - 1);
        end else if ((state == ST_UART_WAIT) && (tcnt != '0)) begin
            tcnt <= tcnt - TW'(1);
        end
    end

    assign timeout = (state == ST_UART_WAIT) && (tcnt == '0) && !wait_ok;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates IF fetches and MEM-stage loads/stores onto RAM1, RAM2 and the
// UART, one transaction at a time. BUS_TIMEOUT_EN adds a UART wait watchdog.
//
//  state        | meaning
//  IDLE         | no transaction; D request beats IF
//  SRAM_ACC     | SRAM en/oe or en/we low for SRAM_WAIT cycles
//  UART_RD      | rdn low for UART_PULSE cycles
//  UART_WR      | wrn low, ram1 bus driven, for UART_PULSE cycles
//  UART_WAIT    | waiting for tbre and tsre (or watchdog)
//  DONE         | ack pulse to served port, strobes released
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter logic [15:0] RAM1_BASE   = DEF_RAM1_BASE,
    parameter logic [15:0] UART_DATA   = DEF_UART_DATA,
    parameter logic [15:0] UART_STAT   = DEF_UART_STAT,
    parameter int          SRAM_WAIT   = 1,
    parameter int          UART_PULSE  = 2,
    parameter int          TIMEOUT_CYC = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_ack,
    input  logic        d_rd,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_rdata,
    output logic        d_ack,
    output logic        d_err,
    output logic        if_stall,
    output logic        d_stall,
    output logic [17:0] ram1_addr,
    output logic [15:0] ram1_dout,
    output logic        ram1_doe,
    input  logic [15:0] ram1_din,
    output logic        ram1_en,
    output logic        ram1_oe,
    output logic        ram1_we,
    output logic [17:0] ram2_addr,
    output logic [15:0] ram2_dout,
    output logic        ram2_doe,
    input  logic [15:0] ram2_din,
    output logic        ram2_en,
    output logic        ram2_oe,
    output logic        ram2_we,
    input  logic        data_ready,
    input  logic        tbre,
    input  logic        tsre,
    output logic        rdn,
    output logic        wrn
);

    localparam int SW = (SRAM_WAIT > 1) ? $clog2(SRAM_WAIT) : 1;

    logic [2:0]    state;
    logic          serve_d;
    logic          tgt_ram1;
    logic [SW-1:0] scnt;
    logic          d_req;
    logic          launch_rd;
    logic          launch_wr;
    logic          pulse_done;
    logic          wait_ok;
    logic [15:0]   din_sel;
    logic          sel_oe;
`ifdef BUS_TIMEOUT_EN
    logic          timeout;
`endif

    assign d_req    = d_rd | d_wr;
    assign if_stall = if_req & ~if_ack;
    assign d_stall  = d_req & ~d_ack;

    // d_wr wins when both d_rd and d_wr are raised.
    assign launch_wr = (state == ST_IDLE) && d_wr && (d_addr == UART_DATA);
    assign launch_rd = (state == ST_IDLE) && d_rd && !d_wr && (d_addr == UART_DATA);

    assign din_sel = tgt_ram1 ? ram1_din : ram2_din;
    assign sel_oe  = tgt_ram1 ? ram1_oe  : ram2_oe;

    uart_port #(
        .UART_PULSE  (UART_PULSE),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_uart (
        .clk        (clk),
        .rst        (rst),
        .state      (state),
        .launch_rd  (launch_rd),
        .launch_wr  (launch_wr),
        .tbre       (tbre),
        .tsre       (tsre),
        .rdn        (rdn),
        .wrn        (wrn),
        .pulse_done (pulse_done),
`ifdef BUS_TIMEOUT_EN
        .timeout    (timeout),
`endif
        .wait_ok    (wait_ok)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            serve_d   <= 1'b0;
            tgt_ram1  <= 1'b0;
            scnt      <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            ram1_addr <= '0;
            ram1_dout <= '0;
            ram1_doe  <= 1'b0;
            ram1_en   <= 1'b1;
            ram1_oe   <= 1'b1;
            ram1_we   <= 1'b1;
            ram2_addr <= '0;
            ram2_dout <= '0;
            ram2_doe  <= 1'b0;
            ram2_en   <= 1'b1;
            ram2_oe   <= 1'b1;
            ram2_we   <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (d_req) begin
                        serve_d <= 1'b1;
                        if (d_addr == UART_STAT) begin
                            // Status is a register read with no bus activity; writes are dropped.
                            if (!d_wr) d_rdata <= uart_status(data_ready, tbre, tsre);
                            d_ack <= 1'b1;
                            state <= ST_DONE;
                        end else if (d_addr == UART_DATA) begin
                            if (d_wr) begin
                                ram1_dout <= d_wdata;
                                ram1_doe  <= 1'b1;
                                state     <= ST_UART_WR;
                            end else begin
                                state     <= ST_UART_RD;
                            end
                        end else if (d_addr >= RAM1_BASE) begin
                            tgt_ram1  <= 1'b1;
                            scnt      <= SW'(SRAM_WAIT - 1);
                            ram1_addr <= {2'b00, d_addr};
                            ram1_dout <= d_wdata;
                            ram1_doe  <= d_wr;
                            ram1_en   <= 1'b0;
                            ram1_oe   <= d_wr;
                            ram1_we   <= ~d_wr;
                            state     <= ST_SRAM_ACC;
                        end else begin
                            tgt_ram1  <= 1'b0;
                            scnt      <= SW'(SRAM_WAIT - 1);
                            ram2_addr <= {2'b00, d_addr};
                            ram2_dout <= d_wdata;
                            ram2_doe  <= d_wr;
                            ram2_en   <= 1'b0;
                            ram2_oe   <= d_wr;
                            ram2_we   <= ~d_wr;
                            state     <= ST_SRAM_ACC;
                        end
                    end else if (if_req) begin
                        serve_d   <= 1'b0;
                        tgt_ram1  <= 1'b0;
                        scnt      <= SW'(SRAM_WAIT - 1);
                        ram2_addr <= {2'b00, if_addr};
                        ram2_doe  <= 1'b0;
                        ram2_en   <= 1'b0;
                        ram2_oe   <= 1'b0;
                        ram2_we   <= 1'b1;
                        state     <= ST_SRAM_ACC;
                    end
                end

                ST_SRAM_ACC: begin
                    if (scnt == '0) begin
                        if (serve_d) begin
                            if (!sel_oe) d_rdata <= din_sel;
                            d_ack <= 1'b1;
                        end else begin
                            if_rdata <= din_sel;
                            if_ack   <= 1'b1;
                        end
                        ram1_oe <= 1'b1;
                        ram1_we <= 1'b1;
                        ram2_oe <= 1'b1;
                        ram2_we <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        scnt <= scnt - SW'(1);
                    end
                end

                ST_UART_RD: begin
                    if (pulse_done) begin
                        d_rdata <= {8'h00, ram1_din[7:0]};
                        d_ack   <= 1'b1;
                        state   <= ST_DONE;
                    end
                end

                ST_UART_WR: begin
                    if (pulse_done) state <= ST_UART_WAIT;
                end

                ST_UART_WAIT: begin
                    if (wait_ok) begin
                        d_ack <= 1'b1;
                        state <= ST_DONE;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (timeout) begin
                        d_rdata <= 16'hFFFF;
                        d_ack   <= 1'b1;
                        state   <= ST_DONE;
                    end
`endif
                end

                ST_DONE: begin
                    ram1_en  <= 1'b1;
                    ram2_en  <= 1'b1;
                    ram1_doe <= 1'b0;
                    ram2_doe <= 1'b0;
                    if_ack   <= 1'b0;
                    d_ack    <= 1'b0;
                    state    <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef BUS_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_err <= 1'b0;
        end else if ((state == ST_UART_WAIT) && timeout) begin
            d_err <= 1'b1;
        end else if (state == ST_DONE) begin
            d_err <= 1'b0;
        end
    end
`else
    assign d_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomized bench for mem_bus_arbiter with SRAM/UART models and
// a flat address-map reference memory.
module tb_mem_bus_arbiter;

    localparam logic [15:0] UART_DATA = 16'hBF00;
    localparam logic [15:0] UART_STAT = 16'hBF01;
    localparam int LAT_SRAM = 2;
    localparam int LAT_STAT = 1;
    localparam int LAT_URD  = 3;
    localparam int NPOOL    = 12;

    logic        clk, rst;
    logic        if_req, d_rd, d_wr;
    logic [15:0] if_addr, d_addr, d_wdata;
    logic [15:0] if_rdata, d_rdata;
    logic        if_ack, d_ack, d_err, if_stall, d_stall;
    logic [17:0] ram1_addr, ram2_addr;
    logic [15:0] ram1_dout, ram2_dout, ram1_din, ram2_din;
    logic        ram1_doe, ram1_en, ram1_oe, ram1_we;
    logic        ram2_doe, ram2_en, ram2_oe, ram2_we;
    logic        data_ready, tbre, tsre, rdn, wrn;

    logic [7:0]  uart_hi, uart_byte;
    logic [15:0] sram1 [0:65535];
    logic [15:0] sram2 [0:65535];
    logic [15:0] ref_mem [logic [15:0]];
    logic [15:0] pool [NPOOL];

    int n_cmp = 0;
    int n_err = 0;

    mem_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
        .if_stall(if_stall), .d_stall(d_stall),
        .ram1_addr(ram1_addr), .ram1_dout(ram1_dout), .ram1_doe(ram1_doe), .ram1_din(ram1_din),
        .ram1_en(ram1_en), .ram1_oe(ram1_oe), .ram1_we(ram1_we),
        .ram2_addr(ram2_addr), .ram2_dout(ram2_dout), .ram2_doe(ram2_doe), .ram2_din(ram2_din),
        .ram2_en(ram2_en), .ram2_oe(ram2_oe), .ram2_we(ram2_we),
        .data_ready(data_ready), .tbre(tbre), .tsre(tsre), .rdn(rdn), .wrn(wrn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // UART shares the RAM1 data bus while rdn is low
    assign ram1_din = !rdn ? {uart_hi, uart_byte} :
                      (!ram1_en && !ram1_oe) ? sram1[ram1_addr[15:0]] : 16'h0000;
    assign ram2_din = (!ram2_en && !ram2_oe) ? sram2[ram2_addr[15:0]] : 16'h0000;

    always @(posedge clk) begin
        if (!ram1_en && !ram1_we) sram1[ram1_addr[15:0]] = ram1_dout;
        if (!ram2_en && !ram2_we) sram2[ram2_addr[15:0]] = ram2_dout;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // one target per cycle, UART never overlaps SRAM enables, upper address bits zero
    always @(negedge clk) begin
        if (!rst) begin
            check("exclusive_targets",
                  {31'b0, !((!rdn || !wrn) && (!ram1_en || !ram2_en)) && !(!ram1_en && !ram2_en) &&
                          !(!rdn && !wrn) && (ram1_en || ram1_addr[17:16] == 2'b00) &&
                          (ram2_en || ram2_addr[17:16] == 2'b00)}, 32'd1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input int kind, input logic [15:0] a, input logic [15:0] wd,
                           input logic both, output int lat, output logic [15:0] rd,
                           output logic other_ack);
        step();
        check("ack_pulse_one_cycle", {30'b0, if_ack, d_ack}, 32'd0);
        case (kind)
            0:       begin if_addr = a; if_req = 1'b1; end
            2, 5:    begin d_addr = a; d_wdata = wd; d_wr = 1'b1; d_rd = both; end
            default: begin d_addr = a; d_rd = 1'b1; end
        endcase
        lat = 0;
        rd = 16'h0;
        other_ack = 1'b0;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            step();
            if ((kind == 0) ? if_ack : d_ack) begin
                lat = i;
                rd = (kind == 0) ? if_rdata : d_rdata;
                other_ack = (kind == 0) ? d_ack : if_ack;
            end
        end
        if_req = 1'b0;
        d_rd = 1'b0;
        d_wr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, kind, pi;
        logic [15:0] a, wd, rd, exp_d;
        logic oth, both, dr;

        rst = 1'b1;
        {if_req, d_rd, d_wr, data_ready, tbre, tsre} = '0;
        if_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0;
        uart_hi = 8'h5A; uart_byte = 8'h00;

        pool[0] = 16'h0000; pool[1] = 16'h0001; pool[2]  = 16'h7FFE; pool[3]  = 16'h7FFF;
        pool[4] = 16'h1234; pool[5] = 16'h0040; pool[6]  = 16'h8000; pool[7]  = 16'h8001;
        pool[8] = 16'hBEFF; pool[9] = 16'hBF02; pool[10] = 16'hFFFF; pool[11] = 16'hC000;
        for (int i = 0; i < NPOOL; i++) begin
            sram1[pool[i]] = 16'($urandom);
            sram2[pool[i]] = 16'($urandom);
            ref_mem[pool[i]] = (pool[i] >= 16'h8000) ? sram1[pool[i]] : sram2[pool[i]];
        end
        sram2[16'h0004] = 16'h6801;
        sram2[16'h0010] = 16'h1357;
        sram2[16'h0020] = 16'h2468;

        #2;
        check("rst_strobes", {26'b0, ram1_en, ram1_oe, ram1_we, ram2_en, ram2_oe, ram2_we}, 32'h3F);
        check("rst_uart_strobes", {30'b0, rdn, wrn}, 32'h3);
        check("rst_doe_ack", {28'b0, ram1_doe, ram2_doe, if_ack, d_ack}, 32'h0);
        check("rst_rdata", {if_rdata, d_rdata}, 32'h0);
        check("rst_err", {31'b0, d_err}, 32'h0);
        step();
        rst = 1'b0;

        // single fetch
        step();
        if_addr = 16'h0004; if_req = 1'b1;
        step();
        check("if_c1_oe_en", {30'b0, ram2_oe, ram2_en}, 32'h0);
        check("if_c1_ack_stall", {30'b0, if_ack, if_stall}, 32'h1);
        step();
        check("if_c2_ack_stall", {30'b0, if_ack, if_stall}, 32'h2);
        check("if_c2_rdata", {16'b0, if_rdata}, 32'h6801);
        check("if_c2_oe", {31'b0, ram2_oe}, 32'h1);
        if_req = 1'b0;
        step();
        check("if_c3_ack", {31'b0, if_ack}, 32'h0);

        // simultaneous IF and D: D served first
        step();
        if_addr = 16'h0020; if_req = 1'b1;
        d_addr = 16'h0010; d_rd = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            check($sformatf("both_c%0d_acks", i), {30'b0, d_ack, if_ack}, {30'b0, i == 2, i == 5});
            check($sformatf("both_c%0d_if_stall", i), {31'b0, if_stall}, {31'b0, i != 5});
            if (i == 1) check("both_c1_d_stall", {31'b0, d_stall}, 32'h1);
            if (i == 2) begin
                check("both_d_rdata", {16'b0, d_rdata}, 32'h1357);
                d_rd = 1'b0;
            end
            if (i == 5) begin
                check("both_if_rdata", {16'b0, if_rdata}, 32'h2468);
                if_req = 1'b0;
            end
        end

        // UART write with late tbre/tsre
        step();
        d_addr = UART_DATA; d_wdata = 16'h0041; d_wr = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            step();
            check($sformatf("uwr_c%0d_wrn_rdn", i), {30'b0, wrn, rdn}, {30'b0, !(i == 1 || i == 2), 1'b1});
            check($sformatf("uwr_c%0d_en_ack", i), {30'b0, ram1_en, d_ack}, {30'b0, 1'b1, i == 10});
            if (i == 1) check("uwr_bus", {15'b0, ram1_doe, ram1_dout}, 32'h10041);
            if (i == 6) tbre = 1'b1;
            if (i == 9) tsre = 1'b1;
            if (i == 10) d_wr = 1'b0;
        end

        // status read
        data_ready = 1'b1;
        step();
        d_addr = UART_STAT; d_rd = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            step();
            check($sformatf("stat_c%0d_ack", i), {31'b0, d_ack}, {31'b0, i == 1});
            check($sformatf("stat_c%0d_strobes", i),
                  {24'b0, ram1_en, ram1_oe, ram1_we, ram2_en, ram2_oe, ram2_we, rdn, wrn}, 32'hFF);
            if (i == 1) begin
                check("stat_rdata", {16'b0, d_rdata}, 32'h0003);
                d_rd = 1'b0;
            end
        end

        // UART read masks upper byte
        uart_byte = 8'($urandom);
        step();
        d_addr = UART_DATA; d_rd = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("urd_c%0d_rdn", i), {30'b0, rdn, ram1_en}, {30'b0, !(i == 1 || i == 2), 1'b1});
            check($sformatf("urd_c%0d_ack", i), {31'b0, d_ack}, {31'b0, i == 3});
            if (i == 3) begin
                check("urd_rdata", {16'b0, d_rdata}, {24'b0, uart_byte});
                d_rd = 1'b0;
            end
        end

        // reset in the middle of an SRAM write
        step();
        d_addr = 16'h0123; d_wdata = 16'hBEEF; d_wr = 1'b1;
        step();
        check("rstw_c1_we_doe", {30'b0, ram2_we, ram2_doe}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("rstw_we_doe_en", {29'b0, ram2_we, ram2_doe, ram2_en}, 32'h5);
        check("rstw_ack", {31'b0, d_ack}, 32'h0);
        d_wr = 1'b0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rstw_no_ack", {30'b0, if_ack, d_ack}, 32'h0);
        end
        run_txn(0, 16'h0004, 16'h0, 1'b0, lat, rd, oth);
        check("rstw_idle_fetch_lat", lat, LAT_SRAM);
        check("rstw_idle_fetch_data", {16'b0, rd}, 32'h6801);

        // randomized traffic against the flat reference map
        for (int t = 0; t < 60; t++) begin
            kind = $urandom_range(0, 5);
            pi = (kind == 0) ? $urandom_range(0, 5) : $urandom_range(0, NPOOL - 1);
            a = pool[pi];
            wd = 16'($urandom);
            both = 1'($urandom_range(0, 1));
            exp_d = 16'h0;
            case (kind)
                3: begin
                    dr = 1'($urandom_range(0, 1));
                    data_ready = dr;
                    tbre = 1'($urandom_range(0, 1));
                    tsre = 1'($urandom_range(0, 1));
                    a = UART_STAT;
                    exp_d = {14'b0, dr, tbre & tsre};
                end
                4: begin
                    uart_byte = 8'($urandom);
                    uart_hi = 8'($urandom);
                    a = UART_DATA;
                    exp_d = {8'h00, uart_byte};
                end
                5: a = UART_STAT;
                default: exp_d = ref_mem[a];
            endcase
            run_txn(kind, a, wd, both, lat, rd, oth);
            check($sformatf("rnd%0d_k%0d_lat", t, kind), lat,
                  (kind == 3 || kind == 5) ? LAT_STAT : (kind == 4) ? LAT_URD : LAT_SRAM);
            check($sformatf("rnd%0d_other_ack", t), {31'b0, oth}, 32'h0);
            if (kind == 2) ref_mem[a] = wd;
            else if (kind != 5) check($sformatf("rnd%0d_k%0d_data@%0h", t, kind, a), {16'b0, rd}, {16'b0, exp_d});
            if (kind != 0) check($sformatf("rnd%0d_err", t), {31'b0, d_err}, 32'h0);
        end

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
